// File: rtl/transaccion_pkg.sv
// Shared helpers for the transaction demux: width derivation, destination
// field extraction and the hysteresis rule used by every pause flag.
package transaccion_pkg;

  function automatic int clog2_f(input int unsigned v);
    int r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_w_f(input int unsigned len);
    return clog2_f(len + 1);
  endfunction

  function automatic int ptr_w_f(input int unsigned len);
    return clog2_f(len);
  endfunction

  function automatic int dest_w_f(input int unsigned n);
    return clog2_f(n);
  endfunction

  // Word is passed zero-extended so one function serves any BITNUMBER up to 64.
  function automatic logic [31:0] dest_of(input logic [63:0] word,
                                          input int unsigned lsb,
                                          input int unsigned dw);
    return 32'((word >> lsb) & ((64'd1 << dw) - 64'd1));
  endfunction

  function automatic logic hyst_next(input logic [31:0] cnt,
                                     input logic [31:0] alto,
                                     input logic [31:0] bajo,
                                     input logic        prev);
    if (cnt >= alto) return 1'b1;
    if (cnt <= bajo) return 1'b0;
    return prev;
  endfunction

endpackage

// File: rtl/transaccion_demux_n_if.sv
// Bus bundle for the transaction demux: producer side, per-destination
// consumer strobes, thresholds and status flags.
interface transaccion_demux_n_if #(
  parameter int BITNUMBER = 8,
  parameter int NUM_DEST  = 2,
  parameter int CNT_W     = 3
);
  logic                          push;
  logic [BITNUMBER-1:0]          data_in;
  logic [NUM_DEST-1:0]           pop;
  logic [CNT_W-1:0]              umbral_alto;
  logic [CNT_W-1:0]              umbral_bajo;
  logic                          main_pause;
  logic                          main_full;
  logic [NUM_DEST-1:0]           dest_pause;
  logic [NUM_DEST-1:0]           can_pop;
  logic [NUM_DEST*BITNUMBER-1:0] data_out;
  logic                          error;

  modport master (
    output push, data_in, pop, umbral_alto, umbral_bajo,
    input  main_pause, main_full, dest_pause, can_pop, data_out, error
  );

  modport slave (
    input  push, data_in, pop, umbral_alto, umbral_bajo,
    output main_pause, main_full, dest_pause, can_pop, data_out, error
  );
endinterface

// File: rtl/fifo_fwft_sinc.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty=0.
// count_nxt exposes the post-edge occupancy so callers can register flags on it.
module fifo_fwft_sinc import transaccion_pkg::*; #(
  parameter  int BITNUMBER = 8,
  parameter  int LENGTH    = 4,
  localparam int CNT_W     = cnt_w_f(LENGTH),
  localparam int PTR_W     = ptr_w_f(LENGTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [BITNUMBER-1:0] data_in,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count_nxt,
  output logic [BITNUMBER-1:0] head
);

  logic [BITNUMBER-1:0] mem_q [LENGTH];
  logic [BITNUMBER-1:0] mem_d [LENGTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(LENGTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head      = mem_q[rd_ptr_q];
  assign count_nxt = count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage is not reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/transaccion_demux_n.sv
// Transaction router: main FIFO drains in strict order into NUM_DEST FWFT
// FIFOs selected by a field of each word, with hysteresis pause flags.
module transaccion_demux_n import transaccion_pkg::*; #(
  parameter  int BITNUMBER = 8,
  parameter  int LENGTH    = 4,
  parameter  int NUM_DEST  = 2,
  parameter  int DEST_LSB  = 4,
  localparam int CNT_W     = cnt_w_f(LENGTH),
  localparam int DEST_W    = dest_w_f(NUM_DEST)
) (
  input  logic                 clk,
  input  logic                 reset,
  transaccion_demux_n_if.slave bus
);

  logic                 m_full, m_empty;
  logic [CNT_W-1:0]     m_count_nxt;
  logic [BITNUMBER-1:0] m_head;

  logic [NUM_DEST-1:0]  d_full, d_empty, d_push;
  logic [CNT_W-1:0]     d_count_nxt [NUM_DEST];
  logic [BITNUMBER-1:0] d_head      [NUM_DEST];

  logic [DEST_W-1:0]    xfer_dest;
  logic                 xfer;

  logic                 main_pause_q, main_pause_d;
  logic [NUM_DEST-1:0]  dest_pause_q, dest_pause_d;
  logic                 error_q, error_d;

  // Destination fullness is the pre-pop value, so a full FIFO never accepts
  // a word in the same cycle it is popped.
  assign xfer_dest = DEST_W'(dest_of(64'(m_head), DEST_LSB, DEST_W));
  assign xfer      = ~m_empty & ~d_full[xfer_dest];

  fifo_fwft_sinc #(
    .BITNUMBER (BITNUMBER),
    .LENGTH    (LENGTH)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.push),
    .pop       (xfer),
    .data_in   (bus.data_in),
    .full      (m_full),
    .empty     (m_empty),
    .count_nxt (m_count_nxt),
    .head      (m_head)
  );

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
    assign d_push[i] = xfer && (xfer_dest == DEST_W'(i));

    fifo_fwft_sinc #(
      .BITNUMBER (BITNUMBER),
      .LENGTH    (LENGTH)
    ) u_dest (
      .clk       (clk),
      .reset     (reset),
      .push      (d_push[i]),
      .pop       (bus.pop[i]),
      .data_in   (m_head),
      .full      (d_full[i]),
      .empty     (d_empty[i]),
      .count_nxt (d_count_nxt[i]),
      .head      (d_head[i])
    );

    assign bus.can_pop[i] = ~d_empty[i];
    assign bus.data_out[i*BITNUMBER +: BITNUMBER] = d_empty[i] ? '0 : d_head[i];
  end

  // Flags follow the post-edge counts so they move in the same cycle as them.
  always_comb begin
    main_pause_d = hyst_next(32'(m_count_nxt), 32'(bus.umbral_alto),
                             32'(bus.umbral_bajo), main_pause_q);
    dest_pause_d = dest_pause_q;
    for (int i = 0; i < NUM_DEST; i++) begin
      dest_pause_d[i] = hyst_next(32'(d_count_nxt[i]), 32'(bus.umbral_alto),
                                  32'(bus.umbral_bajo), dest_pause_q[i]);
    end
    error_d = error_q | (bus.push & m_full) | (|(bus.pop & d_empty));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_pause_q <= 1'b0;
      dest_pause_q <= '0;
      error_q      <= 1'b0;
    end else begin
      main_pause_q <= main_pause_d;
      dest_pause_q <= dest_pause_d;
      error_q      <= error_d;
    end
  end

  assign bus.main_pause = main_pause_q;
  assign bus.main_full  = m_full;
  assign bus.dest_pause = dest_pause_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_transaccion_demux_n.sv
// Bench for transaccion_demux_n: a queue-based reference keeps the expected
// contents of every FIFO; outputs are compared one time unit after each edge.
module tb_transaccion_demux_n;
  localparam int B    = 8;
  localparam int L    = 4;
  localparam int N    = 2;
  localparam int ALTO = 3;
  localparam int BAJO = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  transaccion_demux_n_if #(.BITNUMBER(B), .NUM_DEST(N), .CNT_W(3)) bus ();

  transaccion_demux_n #(
    .BITNUMBER (B),
    .LENGTH    (L),
    .NUM_DEST  (N),
    .DEST_LSB  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [7:0] mq[$];
  logic [7:0] dq0[$];
  logic [7:0] dq1[$];
  logic       m_err;
  logic       m_mp;
  logic [1:0] m_dp;

  typedef struct {
    logic       p;
    logic [7:0] d;
    logic [1:0] pp;
    logic [1:0] e_cp;
    logic [15:0] e_do;
    logic       e_err;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_hyst(input int c, input logic prev);
    if (c >= ALTO) return 1'b1;
    if (c <= BAJO) return 1'b0;
    return prev;
  endfunction

  task automatic check_all();
    logic [15:0] e_do;
    e_do = '0;
    if (dq0.size() > 0) e_do[7:0]  = dq0[0];
    if (dq1.size() > 0) e_do[15:8] = dq1[0];
    chk("can_pop",    64'(bus.can_pop),    64'({dq1.size() > 0, dq0.size() > 0}));
    chk("data_out",   64'(bus.data_out),   64'(e_do));
    chk("main_full",  64'(bus.main_full),  64'(mq.size() == L));
    chk("main_pause", 64'(bus.main_pause), 64'(m_mp));
    chk("dest_pause", 64'(bus.dest_pause), 64'(m_dp));
    chk("error",      64'(bus.error),      64'(m_err));
  endtask

  // One clock of stimulus; reference state advances from pre-edge values.
  task automatic step(input logic p, input logic [7:0] d, input logic [1:0] pp);
    logic full, mv, md;
    full = (mq.size() == L);
    mv   = 1'b0;
    md   = 1'b0;
    if (mq.size() > 0) begin
      md = mq[0][4];
      mv = md ? (dq1.size() < L) : (dq0.size() < L);
    end
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = pp;
    if (pp[0]) begin
      if (dq0.size() > 0) begin
        chk("pop0_word", 64'(bus.data_out[7:0]), 64'(dq0[0]));
        void'(dq0.pop_front());
        n_pop++;
      end else m_err = 1'b1;
    end
    if (pp[1]) begin
      if (dq1.size() > 0) begin
        chk("pop1_word", 64'(bus.data_out[15:8]), 64'(dq1[0]));
        void'(dq1.pop_front());
        n_pop++;
      end else m_err = 1'b1;
    end
    if (mv) begin
      if (md) dq1.push_back(mq.pop_front());
      else    dq0.push_back(mq.pop_front());
    end
    if (p) begin
      if (full) m_err = 1'b1;
      else      mq.push_back(d);
    end
    m_mp    = ref_hyst(mq.size(), m_mp);
    m_dp[0] = ref_hyst(dq0.size(), m_dp[0]);
    m_dp[1] = ref_hyst(dq1.size(), m_dp[1]);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n, input logic p);
    reset       = 1'b1;
    bus.push    = p;
    bus.data_in = 8'h13;
    bus.pop     = '0;
    repeat (n) @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.push = 1'b0;
    mq.delete();
    dq0.delete();
    dq1.delete();
    m_err = 1'b0;
    m_mp  = 1'b0;
    m_dp  = '0;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_pause;
    int   pops_before;

    tbl[0] = '{1'b1, 8'h05, 2'b00, 2'b00, 16'h0000, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 2'b00, 2'b01, 16'h0005, 1'b0};
    tbl[2] = '{1'b1, 8'h15, 2'b00, 2'b01, 16'h0005, 1'b0};
    tbl[3] = '{1'b1, 8'h03, 2'b00, 2'b11, 16'h1505, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 2'b01, 2'b11, 16'h1503, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 2'b11, 2'b00, 16'h0000, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 2'b01, 2'b00, 16'h0000, 1'b1};

    bus.push        = 1'b0;
    bus.data_in     = '0;
    bus.pop         = '0;
    bus.umbral_alto = 3'(ALTO);
    bus.umbral_bajo = 3'(BAJO);
    m_err = 1'b0;
    m_mp  = 1'b0;
    m_dp  = '0;

    // Reset state, then single word and two-destination routing from the table.
    do_reset(2, 1'b0);
    chk("rst_error", 64'(bus.error), 64'(0));
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].p, tbl[i].d, tbl[i].pp);
      chk("tbl_can_pop",  64'(bus.can_pop),  64'(tbl[i].e_cp));
      chk("tbl_data_out", 64'(bus.data_out), 64'(tbl[i].e_do));
      chk("tbl_error",    64'(bus.error),    64'(tbl[i].e_err));
    end

    // Fill destination 0 and main, overflow, then drain.
    do_reset(1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 2'b00);
    chk("t3_main_full",  64'(bus.main_full),     64'(1));
    chk("t3_main_pause", 64'(bus.main_pause),    64'(1));
    chk("t3_dest_pause", 64'(bus.dest_pause[0]), 64'(1));
    chk("t3_error",      64'(bus.error),         64'(1));
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 2'b01);
    chk("t3_pause_clr",  64'(bus.main_pause),    64'(0));
    chk("t3_not_full",   64'(bus.main_full),     64'(0));

    // Head-of-line blocking behind a full destination 0.
    step(1'b1, 8'h0A, 2'b00);
    step(1'b1, 8'h0B, 2'b00);
    step(1'b1, 8'h0C, 2'b00);
    step(1'b1, 8'h10, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'b00);
    chk("t4_blocked", 64'(bus.can_pop[1]), 64'(0));
    step(1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'b00);
    chk("t4_released", 64'(bus.can_pop[1]),     64'(1));
    chk("t4_word",     64'(bus.data_out[15:8]), 64'(8'h10));

    // Streaming: one push per cycle, both consumers popping whatever is ready.
    do_reset(1, 1'b0);
    saw_pause   = 1'b0;
    pops_before = n_pop;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i[0] ? 8'(8'h10 + i) : 8'(i), bus.can_pop);
      saw_pause |= bus.main_pause;
    end
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, bus.can_pop);
    chk("t5_never_paused", 64'(saw_pause),           64'(0));
    chk("t5_delivered",    64'(n_pop - pops_before), 64'(20));
    chk("t5_error",        64'(bus.error),           64'(0));

    // Reset in the middle of traffic, then underflow after it.
    step(1'b1, 8'h01, 2'b00);
    step(1'b1, 8'h11, 2'b00);
    step(1'b1, 8'h02, 2'b00);
    step(1'b1, 8'h12, 2'b00);
    step(1'b0, 8'h00, 2'b00);
    do_reset(1, 1'b1);
    chk("t6_can_pop",  64'(bus.can_pop),    64'(0));
    chk("t6_data_out", 64'(bus.data_out),   64'(0));
    chk("t6_pause",    64'(bus.main_pause), 64'(0));
    chk("t6_error",    64'(bus.error),      64'(0));
    step(1'b0, 8'h00, 2'b10);
    chk("t6_underflow", 64'(bus.error), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
